// File: rtl/sm_vga_timer_if.sv
// Bus port of the VGA timing generator: one CPU-side slave port behind sm_matrix.
// The master drives select/address/write strobe/data; the slave returns combinational read data.
interface sm_vga_timer_if;
    logic        bSel;
    logic [3:0]  bAddr;
    logic        bWrite;
    logic [31:0] bWData;
    logic [31:0] bRData;

    modport master (
        output bSel,
        output bAddr,
        output bWrite,
        output bWData,
        input  bRData
    );

    modport slave (
        input  bSel,
        input  bAddr,
        input  bWrite,
        input  bWData,
        output bRData
    );
endinterface

// File: rtl/sm_vga_timer.sv
// VGA timing generator: pixel/line counters, sync and visible decodes, frame counter,
// sticky vblank flag and a small CPU register file (STATUS, FRAME, CONTROL, POS).
module sm_vga_timer #(
    parameter int unsigned PIX_DIV  = 2,
    parameter int unsigned H_VIS    = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SW     = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_VIS    = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SW     = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          RESET_EN = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    sm_vga_timer_if.slave       bus,
    output logic                hsync,
    output logic                vsync,
    output logic                visible,
    output logic [10:0]         pixX,
    output logic [9:0]          pixY
);

    localparam int unsigned H_TOT = H_VIS + H_FP + H_SW + H_BP;
    localparam int unsigned V_TOT = V_VIS + V_FP + V_SW + V_BP;
    localparam int unsigned DIV_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

    localparam logic [10:0] H_LAST     = 11'(H_TOT - 1);
    localparam logic [10:0] H_VIS_END  = 11'(H_VIS);
    localparam logic [10:0] HS_START   = 11'(H_VIS + H_FP);
    localparam logic [10:0] HS_END     = 11'(H_VIS + H_FP + H_SW);
    localparam logic [9:0]  V_LAST     = 10'(V_TOT - 1);
    localparam logic [9:0]  V_VIS_END  = 10'(V_VIS);
    localparam logic [9:0]  V_VIS_LAST = 10'(V_VIS - 1);
    localparam logic [9:0]  VS_START   = 10'(V_VIS + V_FP);
    localparam logic [9:0]  VS_END     = 10'(V_VIS + V_FP + V_SW);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);

    typedef enum logic [1:0] {
        REG_STATUS  = 2'd0,
        REG_FRAME   = 2'd1,
        REG_CONTROL = 2'd2,
        REG_POS     = 2'd3
    } regSel_e;

    logic             enable;
    logic             vblank;
    logic [31:0]      frameCnt;
    logic [DIV_W-1:0] divCnt;

    regSel_e regSel;
    logic    wrEn;
    logic    wrStatus;
    logic    wrFrame;
    logic    wrControl;
    logic    nextEnable;
    logic    counting;
    logic    pixEn;
    logic    lineEnd;
    logic    frameEnd;
    logic    vblankSet;
    logic    vblankClr;

    // Byte-lane and upper data bits that no register uses.
    logic unusedBits;
    assign unusedBits = ^{bus.bAddr[1:0], bus.bWData[31:1]};

    assign regSel    = regSel_e'(bus.bAddr[3:2]);
    assign wrEn      = bus.bSel & bus.bWrite;
    assign wrStatus  = wrEn && (regSel == REG_STATUS);
    assign wrFrame   = wrEn && (regSel == REG_FRAME);
    assign wrControl = wrEn && (regSel == REG_CONTROL);

    // A CONTROL write that clears enable zeroes the counters on that same edge,
    // and a re-enable only takes effect from the following edge, so counting
    // always restarts cleanly from (0,0) with divCnt=0.
    assign nextEnable = wrControl ? bus.bWData[0] : enable;
    assign counting   = enable & nextEnable;

    assign pixEn     = counting && (divCnt == DIV_LAST);
    assign lineEnd   = pixEn && (pixX == H_LAST);
    assign frameEnd  = lineEnd && (pixY == V_LAST);
    assign vblankSet = lineEnd && (pixY == V_VIS_LAST);
    assign vblankClr = wrStatus && bus.bWData[0];

    // NOTE: sequential state is updated only with non-blocking assignments so every
    // always_ff samples pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enable <= RESET_EN;
        end else begin
            enable <= nextEnable;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            divCnt <= '0;
            pixX   <= '0;
            pixY   <= '0;
        end else if (!counting) begin
            divCnt <= '0;
            pixX   <= '0;
            pixY   <= '0;
        end else begin
            divCnt <= pixEn ? '0 : divCnt + 1'b1;
            if (pixEn) begin
                if (pixX == H_LAST) begin
                    pixX <= '0;
                    pixY <= (pixY == V_LAST) ? 10'd0 : pixY + 10'd1;
                end else begin
                    pixX <= pixX + 11'd1;
                end
            end
        end
    end

    // A FRAME write takes priority over an increment landing on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frameCnt <= '0;
        end else if (!counting || wrFrame) begin
            frameCnt <= '0;
        end else if (frameEnd) begin
            frameCnt <= frameCnt + 32'd1;
        end
    end

    // Sticky flag: hardware set wins over a same-cycle software clear, and it
    // holds its value while the timer is disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vblank <= 1'b0;
        end else if (vblankSet) begin
            vblank <= 1'b1;
        end else if (vblankClr) begin
            vblank <= 1'b0;
        end
    end

    // Sync and visible are pure decodes of the counters; gating with enable keeps
    // both syncs inactive and the picture blanked while stopped.
    assign hsync   = ~(enable && (pixX >= HS_START) && (pixX < HS_END));
    assign vsync   = ~(enable && (pixY >= VS_START) && (pixY < VS_END));
    assign visible = enable && (pixX < H_VIS_END) && (pixY < V_VIS_END);

    logic [31:0] rData;

    // NOTE: assigning a default before the case keeps always_comb free of latches
    // even if a selector value is ever left unhandled.
    always_comb begin
        rData = '0;
        case (regSel)
            REG_STATUS:  rData = {31'b0, vblank};
            REG_FRAME:   rData = frameCnt;
            REG_CONTROL: rData = {31'b0, enable};
            REG_POS:     rData = {6'b0, pixY, 5'b0, pixX};
            default:     rData = '0;
        endcase
    end

    assign bus.bRData = rData;

endmodule

// File: tb/tb_sm_vga_timer.sv
// Self-checking bench for sm_vga_timer: directed scenarios plus randomized bus traffic,
// all compared against an arithmetic model of the raster (clock count -> position/frame).
module tb_sm_vga_timer;

    localparam int H_VIS = 8, H_FP = 2, H_SW = 2, H_BP = 2;
    localparam int V_VIS = 4, V_FP = 1, V_SW = 1, V_BP = 1;
    localparam int H_TOT = H_VIS + H_FP + H_SW + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SW + V_BP;
    localparam int F_TOT = H_TOT * V_TOT;

    localparam logic [3:0] A_STATUS = 4'h0, A_FRAME = 4'h4, A_CONTROL = 4'h8, A_POS = 4'hC;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sm_vga_timer_if bus1();
    sm_vga_timer_if bus3();

    logic        hsync1, vsync1, visible1, hsync3, vsync3, visible3;
    logic [10:0] pixX1, pixX3;
    logic [9:0]  pixY1, pixY3;

    sm_vga_timer #(
        .PIX_DIV(1), .H_VIS(H_VIS), .H_FP(H_FP), .H_SW(H_SW), .H_BP(H_BP),
        .V_VIS(V_VIS), .V_FP(V_FP), .V_SW(V_SW), .V_BP(V_BP), .RESET_EN(1'b1)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1),
        .hsync(hsync1), .vsync(vsync1), .visible(visible1), .pixX(pixX1), .pixY(pixY1)
    );

    sm_vga_timer #(
        .PIX_DIV(3), .H_VIS(H_VIS), .H_FP(H_FP), .H_SW(H_SW), .H_BP(H_BP),
        .V_VIS(V_VIS), .V_FP(V_FP), .V_SW(V_SW), .V_BP(V_BP), .RESET_EN(1'b1)
    ) dut3 (
        .clk(clk), .rst_n(rst_n), .bus(bus3),
        .hsync(hsync3), .vsync(vsync3), .visible(visible3), .pixX(pixX3), .pixY(pixY3)
    );

    int nCompared = 0;
    int nMismatch = 0;

    // Model state: counting clocks since (re)start; everything else is derived arithmetically.
    int unsigned mTicks, mTicks3, mFrameOff;
    bit          mEn, mVblank;

    function automatic logic [23:0] expVideo(int unsigned t, int unsigned pd, bit en);
        int unsigned x, y;
        logic h, v, vis;
        x   = (t / pd) % H_TOT;
        y   = (t / pd / H_TOT) % V_TOT;
        h   = !(en && x >= H_VIS + H_FP && x < H_VIS + H_FP + H_SW);
        v   = !(en && y >= V_VIS + V_FP && y < V_VIS + V_FP + V_SW);
        vis = en && x < H_VIS && y < V_VIS;
        return {11'(x), 10'(y), h, v, vis};
    endfunction

    function automatic logic [31:0] expPos(int unsigned t);
        int unsigned x, y;
        x = t % H_TOT;
        y = (t / H_TOT) % V_TOT;
        return {6'b0, 10'(y), 5'b0, 11'(x)};
    endfunction

    task automatic busIdle();
        bus1.bSel = 1'b0; bus1.bWrite = 1'b0; bus1.bAddr = 4'h0; bus1.bWData = 32'h0;
        bus3.bSel = 1'b0; bus3.bWrite = 1'b0; bus3.bAddr = 4'h0; bus3.bWData = 32'h0;
    endtask

    // One clock edge; the model consumes whatever bus1 presented before the edge.
    task automatic tick();
        bit          wr, nextEn, setV;
        logic [1:0]  a;
        logic [31:0] d;
        int unsigned prevLine, newLine;
        wr = bus1.bSel && bus1.bWrite;
        a  = bus1.bAddr[3:2];
        d  = bus1.bWData;
        @(posedge clk);
        #1;
        nextEn = (wr && a == 2'd2) ? d[0] : mEn;
        setV   = 1'b0;
        if (mEn && nextEn) begin
            prevLine = (mTicks / H_TOT) % V_TOT;
            mTicks++;
            newLine  = (mTicks / H_TOT) % V_TOT;
            setV     = (prevLine == V_VIS - 1) && (newLine == V_VIS);
        end else begin
            mTicks    = 0;
            mFrameOff = 0;
        end
        if (setV) mVblank = 1'b1;
        else if (wr && a == 2'd0 && d[0]) mVblank = 1'b0;
        if (wr && a == 2'd1) mFrameOff = mTicks / F_TOT;
        mEn = nextEn;
        mTicks3++;
    endtask

    task automatic busWrite(input logic [3:0] addr, input logic [31:0] data);
        bus1.bSel = 1'b1; bus1.bWrite = 1'b1; bus1.bAddr = addr; bus1.bWData = data;
        tick();
        busIdle();
    endtask

    task automatic readReg(input logic [3:0] addr, output logic [31:0] data);
        bus1.bSel = 1'b0; bus1.bWrite = 1'b0; bus1.bAddr = addr;
        #1;
        data = bus1.bRData;
    endtask

    task automatic doReset();
        busIdle();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        mTicks = 0; mTicks3 = 0; mFrameOff = 0; mEn = 1'b1; mVblank = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] r;
        doReset();
        nCompared++;
        if ({pixX1, pixY1, hsync1, vsync1, visible1} !== {11'd0, 10'd0, 3'b111}) begin
            nMismatch++;
            $display("FAIL reset_video: got %h required %h", {pixX1, pixY1, hsync1, vsync1, visible1},
                     {11'd0, 10'd0, 3'b111});
        end
        readReg(A_FRAME, r);
        nCompared++;
        if (r !== 32'd0) begin nMismatch++; $display("FAIL reset_frame: got %h required 0", r); end
        readReg(A_CONTROL, r);
        nCompared++;
        if (r !== 32'd1) begin nMismatch++; $display("FAIL reset_control: got %h required 1", r); end
        readReg(A_STATUS, r);
        nCompared++;
        if (r !== 32'd0) begin nMismatch++; $display("FAIL reset_status: got %h required 0", r); end
        // Asynchronous reset landing mid-frame must clear state without a clock edge.
        repeat (20) tick();
        #2;
        rst_n = 1'b0;
        #1;
        nCompared++;
        if ({pixX1, pixY1, pixX3, pixY3} !== 42'd0) begin
            nMismatch++;
            $display("FAIL async_reset_pos: got %h required 0", {pixX1, pixY1, pixX3, pixY3});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_free_run();
        logic [31:0] r;
        logic [23:0] e;
        doReset();
        for (int i = 1; i <= 2 * F_TOT; i++) begin
            tick();
            e = expVideo(mTicks, 1, 1'b1);
            nCompared++;
            if ({pixX1, pixY1, hsync1, vsync1, visible1} !== e) begin
                nMismatch++;
                $display("FAIL free_run_video clk %0d: got %h required %h", i,
                         {pixX1, pixY1, hsync1, vsync1, visible1}, e);
            end
            if (i % F_TOT == 0) begin
                readReg(A_FRAME, r);
                nCompared++;
                if (r !== 32'(i / F_TOT)) begin
                    nMismatch++;
                    $display("FAIL free_run_frame clk %0d: got %0d required %0d", i, r, i / F_TOT);
                end
            end
        end
    endtask

    task automatic test_vblank();
        logic [31:0] r;
        doReset();
        repeat (55) tick();
        readReg(A_STATUS, r);
        nCompared++;
        if (r !== 32'd0) begin nMismatch++; $display("FAIL vblank_before: got %h required 0", r); end
        tick();
        readReg(A_STATUS, r);
        nCompared++;
        if (r !== 32'd1) begin nMismatch++; $display("FAIL vblank_set: got %h required 1", r); end
        busWrite(A_STATUS, 32'h1);
        readReg(A_STATUS, r);
        nCompared++;
        if (r !== 32'd0) begin nMismatch++; $display("FAIL vblank_w1c: got %h required 0", r); end
        // Clear attempt on the very edge the next frame sets the flag.
        repeat (F_TOT + 55 - 57) tick();
        busWrite(A_STATUS, 32'h1);
        readReg(A_STATUS, r);
        nCompared++;
        if (r !== 32'd1) begin nMismatch++; $display("FAIL vblank_set_wins: got %h required 1", r); end
    endtask

    task automatic test_pixdiv3();
        logic [23:0] e;
        doReset();
        for (int i = 1; i <= 3 * F_TOT; i++) begin
            tick();
            e = expVideo(mTicks3, 3, 1'b1);
            nCompared++;
            if ({pixX3, pixY3, hsync3, vsync3, visible3} !== e) begin
                nMismatch++;
                $display("FAIL pixdiv3_video clk %0d: got %h required %h", i,
                         {pixX3, pixY3, hsync3, vsync3, visible3}, e);
            end
        end
        bus3.bAddr = A_FRAME;
        #1;
        nCompared++;
        if (bus3.bRData !== 32'd1) begin
            nMismatch++;
            $display("FAIL pixdiv3_frame: got %0d required 1", bus3.bRData);
        end
        bus3.bAddr = 4'h0;
    endtask

    task automatic test_control();
        logic [31:0] r;
        doReset();
        repeat (2 * H_TOT + 5) tick();
        nCompared++;
        if ({pixX1, pixY1} !== {11'd5, 10'd2}) begin
            nMismatch++;
            $display("FAIL control_pre_pos: got %h required %h", {pixX1, pixY1}, {11'd5, 10'd2});
        end
        busWrite(A_CONTROL, 32'h0);
        for (int i = 0; i < 4; i++) begin
            nCompared++;
            if ({pixX1, pixY1, hsync1, vsync1, visible1} !== {21'd0, 3'b110}) begin
                nMismatch++;
                $display("FAIL control_disabled %0d: got %h required %h", i,
                         {pixX1, pixY1, hsync1, vsync1, visible1}, {21'd0, 3'b110});
            end
            tick();
        end
        readReg(A_CONTROL, r);
        nCompared++;
        if (r !== 32'd0) begin nMismatch++; $display("FAIL control_read0: got %h required 0", r); end
        busWrite(A_CONTROL, 32'hFFFF_FFFF);
        nCompared++;
        if ({pixX1, pixY1, visible1} !== {21'd0, 1'b1}) begin
            nMismatch++;
            $display("FAIL control_reenable: got %h required %h", {pixX1, pixY1, visible1}, {21'd0, 1'b1});
        end
        tick();
        nCompared++;
        if (pixX1 !== 11'd1) begin nMismatch++; $display("FAIL control_restart: got %0d required 1", pixX1); end
        repeat (F_TOT) tick();
        readReg(A_FRAME, r);
        nCompared++;
        if (r !== 32'd1) begin nMismatch++; $display("FAIL frame_before_clear: got %0d required 1", r); end
        busWrite(A_FRAME, 32'h1234);
        readReg(A_FRAME, r);
        nCompared++;
        if (r !== 32'd0) begin nMismatch++; $display("FAIL frame_clear: got %0d required 0", r); end
        readReg(A_POS, r);
        nCompared++;
        if (r !== expPos(mTicks)) begin
            nMismatch++;
            $display("FAIL pos_read: got %h required %h", r, expPos(mTicks));
        end
    endtask

    task automatic test_random();
        logic [31:0] r;
        logic [23:0] e;
        int unsigned sel;
        doReset();
        for (int i = 0; i < 2000; i++) begin
            sel = $urandom_range(0, 63);
            case (sel)
                0:       busWrite(A_CONTROL, $urandom);
                1, 2:    busWrite(A_CONTROL, 32'h1);
                3, 4:    busWrite(A_STATUS, $urandom);
                5:       busWrite(A_FRAME, $urandom);
                6:       busWrite(A_POS, $urandom);
                default: tick();
            endcase
            e = expVideo(mTicks, 1, mEn);
            nCompared++;
            if ({pixX1, pixY1, hsync1, vsync1, visible1} !== e) begin
                nMismatch++;
                $display("FAIL rand_video %0d: got %h required %h", i, {pixX1, pixY1, hsync1, vsync1, visible1}, e);
            end
            e = expVideo(mTicks3, 3, 1'b1);
            nCompared++;
            if ({pixX3, pixY3, hsync3, vsync3, visible3} !== e) begin
                nMismatch++;
                $display("FAIL rand_video3 %0d: got %h required %h", i, {pixX3, pixY3, hsync3, vsync3, visible3}, e);
            end
            readReg(A_STATUS, r);
            nCompared++;
            if (r !== {31'b0, mVblank}) begin
                nMismatch++;
                $display("FAIL rand_status %0d: got %h required %h", i, r, {31'b0, mVblank});
            end
            readReg(A_FRAME, r);
            nCompared++;
            if (r !== 32'(mTicks / F_TOT - mFrameOff)) begin
                nMismatch++;
                $display("FAIL rand_frame %0d: got %0d required %0d", i, r, mTicks / F_TOT - mFrameOff);
            end
            readReg(A_CONTROL, r);
            nCompared++;
            if (r !== {31'b0, mEn}) begin
                nMismatch++;
                $display("FAIL rand_control %0d: got %h required %h", i, r, {31'b0, mEn});
            end
            readReg(A_POS, r);
            nCompared++;
            if (r !== expPos(mTicks)) begin
                nMismatch++;
                $display("FAIL rand_pos %0d: got %h required %h", i, r, expPos(mTicks));
            end
            busIdle();
        end
    endtask

    initial begin
        busIdle();
        test_reset();
        test_free_run();
        test_vblank();
        test_pixdiv3();
        test_control();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule
